// File: rtl/qspi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qspi_pkg
//  Description : Shared types and constants for the multi-channel QSPI
//                controller: FSM state encoding, default quad opcodes and
//                the nibble-count helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package qspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_DATA  = 3'd4,
        ST_DONE  = 3'd5,
        ST_GAP   = 3'd6
    } qspi_state_t;

    localparam logic [7:0] c_rd_cmd = 8'hEB;
    localparam logic [7:0] c_wr_cmd = 8'h38;

    // Width of the shared slot / gap down-counter.
    localparam int c_cnt_w = 16;

    // Number of 4-bit slots needed to move a field of the given bit width.
    function automatic logic [c_cnt_w-1:0] nib_count(input int bits);
        return c_cnt_w'(bits / 4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/qspi_line_cache.sv
`default_nettype none
// ============================================================================
//  Module      : qspi_line_cache
//  Description : One-entry read cache (valid, channel, address, data) with
//                lookup, fill on bus-read completion, write-through update
//                and flush.  Flush beats both fill and lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
module qspi_line_cache
    import qspi_pkg::*;
#(
    parameter int CS_W     = 2,
    parameter int ADDR_W   = 24,
    parameter int DATA_W   = 32,
    parameter int CACHE_EN = 1
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [CS_W-1:0]   lk_sel,
    input  logic [ADDR_W-1:0] lk_addr,
    output logic              lk_hit,
    output logic [DATA_W-1:0] lk_data,
    input  logic              ld_en,
    input  logic [CS_W-1:0]   ld_sel,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              wr_en,
    input  logic [CS_W-1:0]   wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic              r_valid;
    logic [CS_W-1:0]   r_sel;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              w_wr_match;

    assign w_wr_match = r_valid && (r_sel == wr_sel) && (r_addr == wr_addr);
    // A same-cycle flush forces the lookup to miss so the read goes to the bus.
    assign lk_hit  = (CACHE_EN != 0) && r_valid && !flush &&
                     (r_sel == lk_sel) && (r_addr == lk_addr);
    assign lk_data = r_data;

    // Entry register: flush clears, bus read fills, matching write updates data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_sel   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (ld_en) begin
            r_valid <= 1'b1;
            r_sel   <= ld_sel;
            r_addr  <= ld_addr;
            r_data  <= ld_data;
        end else if (wr_en && w_wr_match) begin
            r_data  <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/qspi_multi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : qspi_multi_ctrl
//  Description : QPI (4-line) controller for several chip-select channels
//                (flash ROM, PSRAM).  Each nibble slot is two clk cycles
//                (sclk low then high).  Reads may be served from a one-entry
//                cache; out-of-range channels complete at once with err.
//  Revision    : 1.0 - initial release
// ============================================================================
module qspi_multi_ctrl
    import qspi_pkg::*;
#(
    parameter int         NUM_CS    = 2,
    parameter int         ADDR_W    = 24,
    parameter int         DATA_W    = 32,
    parameter int         DUMMY_NIB = 4,
    parameter int         CS_GAP    = 2,
    parameter logic [7:0] RD_CMD    = c_rd_cmd,
    parameter logic [7:0] WR_CMD    = c_wr_cmd,
    parameter int         CACHE_EN  = 1,
    // One extra bit so that out-of-range channel numbers can be presented and flagged.
    localparam int        CS_W      = $clog2(NUM_CS) + 1
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              flush,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic              hit,
    output logic [DATA_W-1:0] rdata,
    output logic              sclk,
    output logic [NUM_CS-1:0] cs_n,
    output logic [3:0]        io_out,
    input  logic [3:0]        io_in,
    output logic [3:0]        io_oe
);

    localparam int c_tx_w = 8 + ADDR_W + DATA_W;

    qspi_state_t        r_state, w_state_nxt;
    logic               r_half, w_half_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic [c_tx_w-1:0]  r_tx, w_tx_nxt;
    logic [DATA_W-1:0]  r_rx, w_rx_nxt, w_rx_shift;
    logic [DATA_W-1:0]  r_rdata, w_rdata_nxt;
    logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic [CS_W-1:0]    r_sel, w_sel_nxt;
    logic               r_we, w_we_nxt, r_err, w_err_nxt, r_hit, w_hit_nxt;
    logic               w_sel_ok, w_cache_hit, w_load, w_wr_upd, w_bus, w_drive;
    logic [DATA_W-1:0]  w_cache_data;

    assign w_sel_ok   = (cs_sel < CS_W'(NUM_CS));
    assign w_rx_shift = {r_rx[DATA_W-5:0], io_in};
    assign w_bus      = r_state inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA};
    assign w_drive    = (r_state inside {ST_CMD, ST_ADDR}) || (r_state == ST_DATA && r_we);

    assign ready  = (r_state == ST_IDLE);
    assign done   = (r_state == ST_DONE);
    assign err    = done && r_err;
    assign hit    = done && r_hit;
    assign rdata  = r_rdata;
    assign sclk   = r_half;
    assign io_oe  = {4{w_drive}};
    assign io_out = w_drive ? r_tx[c_tx_w-1 -: 4] : 4'h0;

    qspi_line_cache #(
        .CS_W     (CS_W),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .CACHE_EN (CACHE_EN)
    ) u_cache (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .lk_sel  (cs_sel),
        .lk_addr (addr),
        .lk_hit  (w_cache_hit),
        .lk_data (w_cache_data),
        .ld_en   (w_load),
        .ld_sel  (r_sel),
        .ld_addr (r_addr),
        .ld_data (w_rx_shift),
        .wr_en   (w_wr_upd),
        .wr_sel  (cs_sel),
        .wr_addr (addr),
        .wr_data (wdata)
    );

    // Drive the selected chip select low only while a bus phase is active.
    always_comb begin
        cs_n = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (w_bus && r_sel == CS_W'(i)) cs_n[i] = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_half  <= 1'b0;
            r_cnt   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_rdata <= '0;
            r_addr  <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_hit   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_half  <= w_half_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tx    <= w_tx_nxt;
            r_rx    <= w_rx_nxt;
            r_rdata <= w_rdata_nxt;
            r_addr  <= w_addr_nxt;
            r_sel   <= w_sel_nxt;
            r_we    <= w_we_nxt;
            r_err   <= w_err_nxt;
            r_hit   <= w_hit_nxt;
        end
    end

    // Next-state logic: request decode, slot sequencing and completion gap.
    always_comb begin
        w_state_nxt = r_state;
        w_half_nxt  = r_half;
        w_cnt_nxt   = r_cnt;
        w_tx_nxt    = r_tx;
        w_rx_nxt    = r_rx;
        w_rdata_nxt = r_rdata;
        w_addr_nxt  = r_addr;
        w_sel_nxt   = r_sel;
        w_we_nxt    = r_we;
        w_err_nxt   = r_err;
        w_hit_nxt   = r_hit;
        w_load      = 1'b0;
        w_wr_upd    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_err_nxt  = 1'b0;
                    w_hit_nxt  = 1'b0;
                    w_half_nxt = 1'b0;
                    if (!w_sel_ok) begin
                        w_state_nxt = ST_DONE;
                        w_err_nxt   = 1'b1;
                        w_rdata_nxt = '0;
                    end else if (!we && w_cache_hit) begin
                        w_state_nxt = ST_DONE;
                        w_hit_nxt   = 1'b1;
                        w_rdata_nxt = w_cache_data;
                    end else begin
                        w_state_nxt = ST_CMD;
                        w_cnt_nxt   = nib_count(8) - c_cnt_w'(1);
                        w_tx_nxt    = {(we ? WR_CMD : RD_CMD), addr,
                                       (we ? wdata : {DATA_W{1'b0}})};
                        w_we_nxt    = we;
                        w_sel_nxt   = cs_sel;
                        w_addr_nxt  = addr;
                        w_wr_upd    = we;
                    end
                end
            end
            ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
                w_half_nxt = ~r_half;
                // Slot boundaries fall on the edge that ends the sclk-high cycle.
                if (r_half) begin
                    if (r_state != ST_DUMMY) w_tx_nxt = {r_tx[c_tx_w-5:0], 4'h0};
                    if (r_state == ST_DATA && !r_we) w_rx_nxt = w_rx_shift;
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - c_cnt_w'(1);
                    end else begin
                        case (r_state)
                            ST_CMD: begin
                                w_state_nxt = ST_ADDR;
                                w_cnt_nxt   = nib_count(ADDR_W) - c_cnt_w'(1);
                            end
                            ST_ADDR: begin
                                if (!r_we && DUMMY_NIB > 0) begin
                                    w_state_nxt = ST_DUMMY;
                                    w_cnt_nxt   = c_cnt_w'(DUMMY_NIB - 1);
                                end else begin
                                    w_state_nxt = ST_DATA;
                                    w_cnt_nxt   = nib_count(DATA_W) - c_cnt_w'(1);
                                end
                            end
                            ST_DUMMY: begin
                                w_state_nxt = ST_DATA;
                                w_cnt_nxt   = nib_count(DATA_W) - c_cnt_w'(1);
                            end
                            default: begin
                                w_state_nxt = ST_DONE;
                                if (!r_we) begin
                                    w_rdata_nxt = w_rx_shift;
                                    w_load      = 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
            ST_DONE: begin
                if (CS_GAP > 0) begin
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = c_cnt_w'(CS_GAP - 1);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) w_state_nxt = ST_IDLE;
                else             w_cnt_nxt   = r_cnt - c_cnt_w'(1);
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_qspi_multi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qspi_multi_ctrl
//  Description : Self-checking bench for qspi_multi_ctrl with a QPI slave
//                model and a scoreboard of expected completions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qspi_multi_ctrl;

    localparam int NUM_CS    = 2;
    localparam int ADDR_W    = 24;
    localparam int DATA_W    = 32;
    localparam int DUMMY_NIB = 4;
    localparam int CS_GAP    = 2;
    localparam int N_RD      = 2 + ADDR_W/4 + DUMMY_NIB + DATA_W/4;
    localparam int N_WR      = 2 + ADDR_W/4 + DATA_W/4;
    localparam int LAT_RD    = 2*N_RD + 1;
    localparam int LAT_WR    = 2*N_WR + 1;
    localparam int RD_DATA_SLOT = 2 + ADDR_W/4 + DUMMY_NIB;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
        logic              hit;
        int                lat;
    } exp_t;

    exp_t sb[$];

    logic clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0, flush = 1'b0;
    logic [1:0]        cs_sel = '0;
    logic [ADDR_W-1:0] addr   = '0;
    logic [DATA_W-1:0] wdata  = '0;
    logic [3:0]        io_in  = '0;
    logic              ready, done, err, hit, sclk;
    logic [DATA_W-1:0] rdata;
    logic [NUM_CS-1:0] cs_n;
    logic [3:0]        io_out, io_oe;

    int checks = 0, errors = 0;
    int sclk_edges = 0, slot = 0;
    logic cs_seen = 1'b0;
    logic [NUM_CS-1:0] last_cs = '1;
    logic [DATA_W-1:0] slave_word = '0;
    logic [3:0] nib_q[$];
    logic [3:0] oe_q[$];

    qspi_multi_ctrl #(
        .NUM_CS(NUM_CS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DUMMY_NIB(DUMMY_NIB),
        .CS_GAP(CS_GAP), .RD_CMD(8'hEB), .WR_CMD(8'h38), .CACHE_EN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .cs_sel(cs_sel), .addr(addr),
        .wdata(wdata), .flush(flush), .ready(ready), .done(done), .err(err),
        .hit(hit), .rdata(rdata), .sclk(sclk), .cs_n(cs_n), .io_out(io_out),
        .io_in(io_in), .io_oe(io_oe)
    );

    always #5 clk = ~clk;

    always @(posedge sclk) sclk_edges++;

    // QPI slave: presents read data in data slots, logs every driven nibble.
    always @(negedge clk) begin
        if (cs_n == '1) begin
            slot = 0;
            io_in = 4'h0;
        end else begin
            cs_seen = 1'b1;
            last_cs = cs_n;
            if (sclk == 1'b0) begin
                if (slot >= RD_DATA_SLOT && slot < RD_DATA_SLOT + DATA_W/4)
                    io_in = slave_word[DATA_W-1-4*(slot-RD_DATA_SLOT) -: 4];
                else
                    io_in = 4'h0;
            end else begin
                nib_q.push_back(io_out);
                oe_q.push_back(io_oe);
                slot++;
            end
        end
    end

    task automatic issue(input logic w, input logic [1:0] s, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic f);
        int k = 0;
        while (ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        we = w; cs_sel = s; addr = a; wdata = d; flush = f; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0; flush = 1'b0; we = 1'b0;
    endtask

    // Returns the cycle number (acceptance edge = 0) in which done is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (done !== 1'b1 && lat < 300);
    endtask

    task automatic test_reset();
        #12;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", ready); end
        checks++; if (cs_n !== 2'b11) begin errors++; $display("FAIL rst_cs_n: got %b want 11", cs_n); end
        checks++; if ({done, err, hit, sclk} !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b want 0000", {done, err, hit, sclk}); end
        checks++; if ({io_oe, io_out} !== 8'h00) begin errors++; $display("FAIL rst_io: got %h want 00", {io_oe, io_out}); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    endtask

    task automatic test_read_miss();
        exp_t e; int lat; int bad; logic [31:0] hdr;
        hdr = {8'hEB, 24'h000100};
        slave_word = 32'hDEADBEEF;
        nib_q.delete(); oe_q.delete();
        sb.push_back('{32'hDEADBEEF, 1'b0, 1'b0, LAT_RD});
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 2'd0, 24'h000100, 32'h0, 1'b0);
        wait_done(lat);
        e = sb.pop_front();
        checks++; if (lat != e.lat) begin errors++; $display("FAIL rd_miss_lat: got %0d want %0d", lat, e.lat); end
        checks++; if (rdata !== e.rdata) begin errors++; $display("FAIL rd_miss_rdata: got %h want %h", rdata, e.rdata); end
        checks++; if ({err, hit} !== {e.err, e.hit}) begin errors++; $display("FAIL rd_miss_flags: got %b want %b", {err, hit}, {e.err, e.hit}); end
        checks++; if (cs_n !== 2'b11 || last_cs !== 2'b10) begin errors++; $display("FAIL rd_miss_cs: got %b/%b want 11/10", cs_n, last_cs); end
        checks++; if (nib_q.size() != N_RD) begin errors++; $display("FAIL rd_miss_slots: got %0d want %0d", nib_q.size(), N_RD); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= nib_q.size() || nib_q[i] !== hdr[31-4*i -: 4]) begin
                errors++; $display("FAIL rd_miss_nib%0d: got %h want %h", i, (i < nib_q.size()) ? nib_q[i] : 4'hx, hdr[31-4*i -: 4]);
            end
        end
        bad = 0;
        for (int i = 0; i < oe_q.size(); i++)
            if (oe_q[i] !== ((i < 2 + ADDR_W/4) ? 4'hF : 4'h0)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rd_miss_oe: got %0d bad slots want 0", bad); end
    endtask

    task automatic test_read_hit();
        exp_t e; int lat; int edges0;
        edges0 = sclk_edges; cs_seen = 1'b0;
        sb.push_back('{32'hDEADBEEF, 1'b0, 1'b1, 1});
        issue(1'b0, 2'd0, 24'h000100, 32'h0, 1'b0);
        wait_done(lat);
        e = sb.pop_front();
        checks++; if (lat != e.lat) begin errors++; $display("FAIL rd_hit_lat: got %0d want %0d", lat, e.lat); end
        checks++; if ({err, hit} !== {e.err, e.hit}) begin errors++; $display("FAIL rd_hit_flags: got %b want %b", {err, hit}, {e.err, e.hit}); end
        checks++; if (rdata !== e.rdata) begin errors++; $display("FAIL rd_hit_rdata: got %h want %h", rdata, e.rdata); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rd_hit_pulse: got %b want 0", done); end
        checks++; if (sclk_edges != edges0 || cs_seen !== 1'b0) begin errors++; $display("FAIL rd_hit_nobus: got %0d edges cs %b want 0 edges cs 0", sclk_edges - edges0, cs_seen); end
    endtask

    task automatic test_write();
        exp_t e; int lat; int bad; logic [63:0] frame;
        frame = {8'h38, 24'h000010, 32'h12345678};
        nib_q.delete(); oe_q.delete();
        sb.push_back('{32'hDEADBEEF, 1'b0, 1'b0, LAT_WR});
        issue(1'b1, 2'd1, 24'h000010, 32'h12345678, 1'b0);
        wait_done(lat);
        e = sb.pop_front();
        checks++; if (lat != e.lat) begin errors++; $display("FAIL wr_lat: got %0d want %0d", lat, e.lat); end
        checks++; if (rdata !== e.rdata) begin errors++; $display("FAIL wr_rdata_kept: got %h want %h", rdata, e.rdata); end
        checks++; if (last_cs !== 2'b01) begin errors++; $display("FAIL wr_cs: got %b want 01", last_cs); end
        checks++; if (nib_q.size() != N_WR) begin errors++; $display("FAIL wr_slots: got %0d want %0d", nib_q.size(), N_WR); end
        bad = 0;
        for (int i = 0; i < nib_q.size() && i < 16; i++)
            if (nib_q[i] !== frame[63-4*i -: 4] || oe_q[i] !== 4'hF) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL wr_nibbles: got %0d bad slots want 0", bad); end
    endtask

    task automatic test_write_through();
        exp_t e; int lat;
        sb.push_back('{32'hDEADBEEF, 1'b0, 1'b0, LAT_WR});
        issue(1'b1, 2'd0, 24'h000100, 32'hCAFEF00D, 1'b0);
        wait_done(lat);
        e = sb.pop_front();
        checks++; if (lat != e.lat) begin errors++; $display("FAIL wt_wr_lat: got %0d want %0d", lat, e.lat); end
        slave_word = 32'h0BADF00D;
        sb.push_back('{32'hCAFEF00D, 1'b0, 1'b1, 1});
        issue(1'b0, 2'd0, 24'h000100, 32'h0, 1'b0);
        wait_done(lat);
        e = sb.pop_front();
        checks++; if (lat != e.lat || hit !== e.hit) begin errors++; $display("FAIL wt_rd_hit: got lat %0d hit %b want lat %0d hit %b", lat, hit, e.lat, e.hit); end
        checks++; if (rdata !== e.rdata) begin errors++; $display("FAIL wt_rd_data: got %h want %h", rdata, e.rdata); end
    endtask

    task automatic test_flush_read();
        exp_t e; int lat;
        slave_word = 32'h0BADF00D;
        sb.push_back('{32'h0BADF00D, 1'b0, 1'b0, LAT_RD});
        issue(1'b0, 2'd0, 24'h000100, 32'h0, 1'b1);
        wait_done(lat);
        e = sb.pop_front();
        checks++; if (lat != e.lat || hit !== e.hit) begin errors++; $display("FAIL flush_rd: got lat %0d hit %b want lat %0d hit %b", lat, hit, e.lat, e.hit); end
        checks++; if (rdata !== e.rdata) begin errors++; $display("FAIL flush_rd_data: got %h want %h", rdata, e.rdata); end
    endtask

    task automatic test_bad_sel();
        exp_t e; int lat; int edges0;
        edges0 = sclk_edges; cs_seen = 1'b0;
        sb.push_back('{32'h0, 1'b1, 1'b0, 1});
        issue(1'b0, 2'd2, 24'h000100, 32'h0, 1'b0);
        wait_done(lat);
        e = sb.pop_front();
        checks++; if (lat != e.lat || {err, hit} !== {e.err, e.hit}) begin errors++; $display("FAIL badsel: got lat %0d err/hit %b want lat %0d err/hit %b", lat, {err, hit}, e.lat, {e.err, e.hit}); end
        checks++; if (rdata !== e.rdata) begin errors++; $display("FAIL badsel_rdata: got %h want %h", rdata, e.rdata); end
        checks++; if (sclk_edges != edges0 || cs_seen !== 1'b0) begin errors++; $display("FAIL badsel_nobus: got %0d edges cs %b want 0 edges cs 0", sclk_edges - edges0, cs_seen); end
        // The earlier entry must survive an erroneous request.
        sb.push_back('{32'h0BADF00D, 1'b0, 1'b1, 1});
        issue(1'b0, 2'd0, 24'h000100, 32'h0, 1'b0);
        wait_done(lat);
        e = sb.pop_front();
        checks++; if (lat != e.lat || hit !== e.hit || rdata !== e.rdata) begin errors++; $display("FAIL badsel_cache: got lat %0d hit %b data %h want lat %0d hit %b data %h", lat, hit, rdata, e.lat, e.hit, e.rdata); end
    endtask

    task automatic test_back_to_back();
        exp_t e; int lat; int g; int pulses;
        sb.push_back('{32'h0BADF00D, 1'b0, 1'b0, LAT_WR});
        issue(1'b1, 2'd1, 24'h000020, 32'hA5A5A5A5, 1'b0);
        wait_done(lat);
        e = sb.pop_front();
        checks++; if (lat != e.lat || rdata !== e.rdata) begin errors++; $display("FAIL b2b_wr: got lat %0d data %h want lat %0d data %h", lat, rdata, e.lat, e.rdata); end
        g = 0;
        while (ready !== 1'b1 && g < 50) begin
            req = (g == 1); we = 1'b0; cs_sel = 2'd1; addr = 24'h000040;
            @(negedge clk);
            g++;
        end
        req = 1'b0;
        checks++; if (g != CS_GAP + 1) begin errors++; $display("FAIL b2b_gap: got %0d want %0d", g, CS_GAP + 1); end
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        checks++; if (pulses != 0 || ready !== 1'b1) begin errors++; $display("FAIL b2b_ignored: got %0d done ready %b want 0 done ready 1", pulses, ready); end
        slave_word = 32'h13572468;
        sb.push_back('{32'h13572468, 1'b0, 1'b0, LAT_RD});
        issue(1'b0, 2'd1, 24'h000040, 32'h0, 1'b0);
        wait_done(lat);
        e = sb.pop_front();
        checks++; if (lat != e.lat || rdata !== e.rdata || last_cs !== 2'b01) begin errors++; $display("FAIL b2b_rd: got lat %0d data %h cs %b want lat %0d data %h cs 01", lat, rdata, last_cs, e.lat, e.rdata); end
    endtask

    task automatic test_reset_mid();
        exp_t e; int lat;
        slave_word = 32'h11112222;
        issue(1'b0, 2'd0, 24'h000200, 32'h0, 1'b0);
        for (int i = 0; i < 15; i++) @(negedge clk);
        checks++; if (cs_n !== 2'b10 || io_oe !== 4'hF) begin errors++; $display("FAIL mid_pre: got cs %b oe %h want cs 10 oe f", cs_n, io_oe); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (cs_n !== 2'b11 || io_oe !== 4'h0) begin errors++; $display("FAIL mid_rst_bus: got cs %b oe %h want cs 11 oe 0", cs_n, io_oe); end
        checks++; if ({ready, done, sclk} !== 3'b100 || rdata !== 32'h0) begin errors++; $display("FAIL mid_rst_state: got rdy/done/sclk %b data %h want 100 data 0", {ready, done, sclk}, rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        slave_word = 32'h55AA55AA;
        sb.push_back('{32'h55AA55AA, 1'b0, 1'b0, LAT_RD});
        issue(1'b0, 2'd0, 24'h000100, 32'h0, 1'b0);
        wait_done(lat);
        e = sb.pop_front();
        checks++; if (lat != e.lat || hit !== e.hit) begin errors++; $display("FAIL mid_rd_miss: got lat %0d hit %b want lat %0d hit %b", lat, hit, e.lat, e.hit); end
        checks++; if (rdata !== e.rdata) begin errors++; $display("FAIL mid_rd_data: got %h want %h", rdata, e.rdata); end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write();
        test_write_through();
        test_flush_read();
        test_bad_sel();
        test_back_to_back();
        test_reset_mid();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_empty: got %0d want 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
